switch_round_ctrl: RTL and testbench

Parametrised round controller for the switch game, sitting between the debounced switch bank and the LED/HEX outputs. It picks a pseudo-random switch, lights its LED and runs a per-round countdown. It judges the player's next switch change as a pass or a fail, inserts an inter-round gap, and keeps a score with a doubling bonus. It replaces the separate prompt, change-detect, check and timer blocks with one FSM that handles any switch count.

---
 rtl/switch_game_pkg.sv | 25 ++
 rtl/switch_round_ctrl_timer.sv | 25 ++
 rtl/switch_round_ctrl.sv | 166 ++++++++++++++++
 tb/tb_switch_round_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/switch_game_pkg.sv
// Shared definitions for the switch game: FSM state encoding, LFSR constants
// and the one-hot helper used to build prompt LEDs.
package switch_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PROMPT = 3'd1,
    ST_PLAY   = 3'd2,
    ST_GAP    = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  // Right-shifting Fibonacci form: taps 16,14,13,11 land on bits 0,2,3,5.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

  function automatic logic [31:0] onehot32(input logic [7:0] idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/switch_round_ctrl_timer.sv
// Seconds down-counter shared by the PLAY and GAP phases; expire flags the
// cycle whose edge takes the count from 1 to 0.
module round_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       en,
  input  logic       load,
  input  logic [5:0] load_val,
  output logic [5:0] count,
  output logic       expire
);

  logic [5:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              r_cnt <= 6'd0;
    else if (load)                        r_cnt <= load_val;
    else if (en && tick && r_cnt != 6'd0) r_cnt <= r_cnt - 6'd1;
  end

  assign count  = r_cnt;
  assign expire = en & tick & ~load & (r_cnt == 6'd1);

endmodule

// File: rtl/switch_round_ctrl.sv
// Round controller for the switch game: prompts a pseudo-random switch, times
// the round, judges the next switch change and keeps a bonus-doubling score.
module switch_round_ctrl
  import switch_game_pkg::*;
#(
  parameter int N_SW         = 10,
  parameter int ROUND_SEC    = 15,
  parameter int GAP_SEC      = 5,
  parameter int BONUS_ROUNDS = 5,
  parameter int SCORE_W      = 12
) (
  input  logic               clk,
  input  logic               reset_btn,
  input  logic               tick_1hz,
  input  logic               start,
  input  logic [N_SW-1:0]    sw,
  output logic [N_SW-1:0]    led,
  output logic [5:0]         time_left,
  output logic [SCORE_W-1:0] score,
  output logic               round_pass,
  output logic               round_fail,
  output logic [2:0]         state
);

  localparam int PC_W = $clog2(BONUS_ROUNDS + 1);

  state_t              r_state, w_next;
  logic [15:0]         r_lfsr;
  logic [N_SW-1:0]     r_sw_prev, r_expected, r_led;
  logic                r_first;
  logic [SCORE_W-1:0]  r_score, r_pts;
  logic [PC_W-1:0]     r_pass_cnt;
  logic                r_pass, r_fail;

  logic [7:0]          w_idx;
  logic [N_SW-1:0]     w_onehot;
  logic                w_move, w_hit, w_expire;
  logic                w_tmr_en, w_tmr_load;
  logic [5:0]          w_tmr_val, w_count;
  logic [SCORE_W:0]    w_sum;
  logic [SCORE_W-1:0]  w_score_sat, w_pts_dbl;
  logic [PC_W-1:0]     w_cnt_inc;
  logic                w_new_game, w_prompt, w_pass, w_fail;

  // Constant-divisor modulo on the low LFSR byte selects the prompt switch.
  assign w_idx    = r_lfsr[7:0] % 8'(N_SW);
  assign w_onehot = N_SW'(onehot32(w_idx));

  // The cycle right after reset release only primes sw_prev.
  assign w_move = ~r_first & (sw != r_sw_prev);
  assign w_hit  = w_move & (sw == r_expected);

  assign w_tmr_load = (r_state == ST_PROMPT) | ((r_state == ST_PLAY) & w_hit);
  assign w_tmr_val  = (r_state == ST_PROMPT) ? 6'(ROUND_SEC) : 6'(GAP_SEC);
  assign w_tmr_en   = ((r_state == ST_PLAY) & ~w_move) | (r_state == ST_GAP);

  round_timer u_timer (
    .clk      (clk),
    .rst      (reset_btn),
    .tick     (tick_1hz),
    .en       (w_tmr_en),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .count    (w_count),
    .expire   (w_expire)
  );

  assign w_sum       = {1'b0, r_score} + {1'b0, r_pts};
  assign w_score_sat = w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];
  assign w_pts_dbl   = r_pts[SCORE_W-1] ? r_pts : (r_pts << 1);
  assign w_cnt_inc   = r_pass_cnt + PC_W'(1);

  always_ff @(posedge clk or posedge reset_btn) begin
    if (reset_btn) r_state <= ST_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_new_game = 1'b0;
    w_prompt   = 1'b0;
    w_pass     = 1'b0;
    w_fail     = 1'b0;
    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          w_new_game = 1'b1;
          w_next     = ST_PROMPT;
        end
      end
      ST_PROMPT: begin
        w_prompt = 1'b1;
        w_next   = ST_PLAY;
      end
      ST_PLAY: begin
        // A move in the same cycle as the final tick takes precedence.
        if (w_move) begin
          if (w_hit) begin
            w_pass = 1'b1;
            w_next = ST_GAP;
          end else begin
            w_fail = 1'b1;
            w_next = ST_OVER;
          end
        end else if (w_expire) begin
          w_fail = 1'b1;
          w_next = ST_OVER;
        end
      end
      ST_GAP: begin
        if (w_expire) w_next = ST_PROMPT;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_btn) begin
    if (reset_btn) begin
      r_lfsr     <= LFSR_SEED;
      r_sw_prev  <= '0;
      r_first    <= 1'b1;
      r_expected <= '0;
      r_led      <= '0;
      r_score    <= '0;
      r_pts      <= SCORE_W'(2);
      r_pass_cnt <= '0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
    end else begin
      r_lfsr    <= lfsr_next(r_lfsr);
      r_sw_prev <= sw;
      r_first   <= 1'b0;
      r_pass    <= w_pass;
      r_fail    <= w_fail;
      if (w_new_game) begin
        r_score    <= '0;
        r_pts      <= SCORE_W'(2);
        r_pass_cnt <= '0;
        r_led      <= '0;
      end
      if (w_prompt) begin
        r_led      <= w_onehot;
        r_expected <= sw ^ w_onehot;
      end
      if (w_pass) begin
        r_score <= w_score_sat;
        r_led   <= '0;
        if (w_cnt_inc == PC_W'(BONUS_ROUNDS)) begin
          r_pass_cnt <= '0;
          r_pts      <= w_pts_dbl;
        end else begin
          r_pass_cnt <= w_cnt_inc;
        end
      end
      if (w_fail) r_led <= '1;
    end
  end

  assign led        = r_led;
  assign time_left  = w_count;
  assign score      = r_score;
  assign round_pass = r_pass;
  assign round_fail = r_fail;
  assign state      = r_state;

endmodule

// File: tb/tb_switch_round_ctrl.sv
// Directed bench for switch_round_ctrl (N_SW=10): prompt selection, passes,
// bonus doubling, wrong moves, timeouts, tie-breaks and async reset.
module tb_switch_round_ctrl;

  localparam int N_SW = 10;

  logic            clk = 1'b0;
  logic            reset_btn, tick_1hz, start;
  logic [N_SW-1:0] sw, led;
  logic [5:0]      time_left;
  logic [11:0]     score;
  logic            round_pass, round_fail;
  logic [2:0]      state;

  int              n_chk = 0;
  int              n_err = 0;
  int              cur_idx;
  logic [15:0]     m_lfsr;
  int              exp_sc [6] = '{2, 4, 6, 8, 10, 14};

  always #5 clk = ~clk;

  switch_round_ctrl #(
    .N_SW(N_SW), .ROUND_SEC(15), .GAP_SEC(5), .BONUS_ROUNDS(5), .SCORE_W(12)
  ) dut (
    .clk        (clk),
    .reset_btn  (reset_btn),
    .tick_1hz   (tick_1hz),
    .start      (start),
    .sw         (sw),
    .led        (led),
    .time_left  (time_left),
    .score      (score),
    .round_pass (round_pass),
    .round_fail (round_fail),
    .state      (state)
  );

  // Reference LFSR: taps 16,14,13,11, shifting right, seeded 16'hACE1.
  always @(posedge clk or posedge reset_btn) begin
    if (reset_btn) m_lfsr <= 16'hACE1;
    else           m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick1();
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
  endtask

  // Called right after the edge that entered PROMPT.
  task automatic enter_play(input string tag);
    logic [N_SW-1:0] e;
    chk({tag, "_prompt"}, 32'(state), 32'd1);
    cur_idx = int'(m_lfsr[7:0]) % N_SW;
    e = '0;
    e[cur_idx] = 1'b1;
    cyc();
    chk({tag, "_play"}, 32'(state), 32'd2);
    chk({tag, "_led"}, 32'(led), 32'(e));
    chk({tag, "_time"}, 32'(time_left), 32'd15);
  endtask

  task automatic gap_to_prompt(input string tag);
    for (int t = 1; t <= 5; t++) begin
      tick1();
      if (t < 5) chk({tag, "_gap_time"}, 32'(time_left), 32'(5 - t));
    end
  endtask

  initial begin
    reset_btn = 1'b1;
    tick_1hz  = 1'b0;
    start     = 1'b0;
    sw        = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_led",   32'(led), 32'd0);
    chk("rst_time",  32'(time_left), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_pulse", {30'd0, round_pass, round_fail}, 32'd0);
    reset_btn = 1'b0;
    cyc();
    chk("idle_hold", 32'(state), 32'd0);

    start = 1'b1;
    cyc();
    start = 1'b0;
    enter_play("r1");

    for (int p = 0; p < 6; p++) begin
      sw[cur_idx] = ~sw[cur_idx];
      cyc();
      chk("pass_pulse", 32'(round_pass), 32'd1);
      chk("pass_nofail", 32'(round_fail), 32'd0);
      chk("pass_state", 32'(state), 32'd3);
      chk("pass_score", 32'(score), 32'(exp_sc[p]));
      chk("pass_time", 32'(time_left), 32'd5);
      chk("pass_led", 32'(led), 32'd0);
      cyc();
      chk("pass_width", 32'(round_pass), 32'd0);
      gap_to_prompt("g");
      enter_play("rn");
    end

    // Wrong switch: unlit neighbour of the prompt.
    sw[(cur_idx + 1) % N_SW] = ~sw[(cur_idx + 1) % N_SW];
    cyc();
    chk("wrong_fail", 32'(round_fail), 32'd1);
    chk("wrong_nopass", 32'(round_pass), 32'd0);
    chk("wrong_state", 32'(state), 32'd4);
    chk("wrong_led", 32'(led), 32'h3FF);
    chk("wrong_score", 32'(score), 32'd14);
    cyc();
    chk("wrong_width", 32'(round_fail), 32'd0);
    chk("over_time_hold", 32'(time_left), 32'd15);

    // Start and tick together in OVER: start wins.
    start    = 1'b1;
    tick_1hz = 1'b1;
    cyc();
    start    = 1'b0;
    tick_1hz = 1'b0;
    chk("restart_score", 32'(score), 32'd0);
    enter_play("r2");

    for (int t = 1; t <= 14; t++) tick1();
    chk("to_time1", 32'(time_left), 32'd1);
    chk("to_still_play", 32'(state), 32'd2);
    tick1();
    chk("to_fail", 32'(round_fail), 32'd1);
    chk("to_time0", 32'(time_left), 32'd0);
    chk("to_state", 32'(state), 32'd4);
    cyc();
    tick1();
    chk("to_over_hold", 32'(time_left), 32'd0);

    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("restart2_score", 32'(score), 32'd0);
    enter_play("r3");

    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_ignored", 32'(state), 32'd2);
    chk("start_ign_time", 32'(time_left), 32'd15);

    // Correct move on the same cycle as the last tick.
    for (int t = 1; t <= 14; t++) tick1();
    chk("tie_time1", 32'(time_left), 32'd1);
    sw[cur_idx] = ~sw[cur_idx];
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
    chk("tie_pass", 32'(round_pass), 32'd1);
    chk("tie_nofail", 32'(round_fail), 32'd0);
    chk("tie_state", 32'(state), 32'd3);
    chk("tie_score", 32'(score), 32'd2);
    chk("tie_time", 32'(time_left), 32'd5);

    gap_to_prompt("g2");
    enter_play("r4");
    cyc();

    // Asynchronous reset mid-PLAY, between clock edges.
    #2 reset_btn = 1'b1;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_led", 32'(led), 32'd0);
    chk("arst_time", 32'(time_left), 32'd0);
    chk("arst_score", 32'(score), 32'd0);
    chk("arst_pulse", {30'd0, round_pass, round_fail}, 32'd0);
    cyc();
    reset_btn = 1'b0;
    cyc();
    chk("post_rst_idle", 32'(state), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
